// File: rtl/bit_serial_multiplier.sv
// ---------------------------------------------------------------------------
// bit_serial_multiplier
//   Unsigned N x N shift-add multiplier built around one 1-bit full adder.
//   Each partial-product addition is done one bit per cycle through that
//   adder. A carry flip-flop links the bits. After each addition, one shift
//   cycle moves {carry,HI,LO} right by one bit. Latency is fixed at N*(N+1)
//   busy cycles, followed by a one-cycle DONE pulse.
//
//   Ports
//     clk      rising-edge clock
//     rst_n    synchronous active-low reset (aborts any operation in flight)
//     start    request; accepted on an edge where start=1 and ready=1
//     a, b     multiplicand / multiplier, sampled on the accept edge only
//     ready    high only while idle
//     busy     high while adding or shifting
//     done     one-cycle pulse; product valid from this cycle on
//     product  a*b, held until the next done
// ---------------------------------------------------------------------------

// 1-bit full adder cell shared by the multiplier datapath.
module fullAdder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

module bit_serial_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [N-1:0]    a_r;
    logic [N-1:0]    hi_r;
    logic [N-1:0]    lo_r;
    logic            carry_r;
    logic [IW-1:0]   bit_idx_r;
    logic [IW-1:0]   iter_r;
    logic            ready_r;
    logic            busy_r;
    logic            done_r;
    logic [2*N-1:0]  product_r;

    logic            fa_x_s;
    logic            fa_y_s;
    logic            fa_sum_s;
    logic            fa_cout_s;

    // Adder operands: accumulator bit plus multiplicand bit gated by the
    // current multiplier LSB. The add always runs, so the latency stays fixed.
    assign fa_x_s = hi_r[bit_idx_r];
    assign fa_y_s = a_r[bit_idx_r] & lo_r[0];

    fullAdder u_fa (
        .x    (fa_x_s),
        .y    (fa_y_s),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Sequencer and datapath: one always block owns all state and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            a_r       <= {N{1'b0}};
            hi_r      <= {N{1'b0}};
            lo_r      <= {N{1'b0}};
            carry_r   <= 1'b0;
            bit_idx_r <= {IW{1'b0}};
            iter_r    <= {IW{1'b0}};
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*N){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r       <= a;
                        lo_r      <= b;
                        hi_r      <= {N{1'b0}};
                        carry_r   <= 1'b0;
                        bit_idx_r <= {IW{1'b0}};
                        iter_r    <= {IW{1'b0}};
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ADD;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                ADD: begin
                    hi_r[bit_idx_r] <= fa_sum_s;
                    carry_r         <= fa_cout_s;
                    if (bit_idx_r == IW'(N - 1)) begin
                        bit_idx_r <= {IW{1'b0}};
                        state_r   <= SHIFT;
                    end else begin
                        bit_idx_r <= bit_idx_r + IW'(1);
                    end
                end
                SHIFT: begin
                    // 2N+1-bit right shift; the carry drops into HI's MSB.
                    carry_r <= 1'b0;
                    hi_r    <= {carry_r, hi_r[N-1:1]};
                    lo_r    <= {hi_r[0], lo_r[N-1:1]};
                    if (iter_r == IW'(N - 1)) begin
                        // Capture the post-shift value, not the current one.
                        product_r <= {carry_r, hi_r, lo_r[N-1:1]};
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        iter_r    <= iter_r + IW'(1);
                        state_r   <= ADD;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ready   = ready_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule
